// File: rtl/clock_pkg.sv
// clock_pkg -- shared definitions for the time display path.
//
// Holds the bit layout of the packed disp_time word produced by clock_12hr,
// the active-low seven-segment codes ({g,f,e,d,c,b,a}), the digit codes used
// for the dash and blank glyphs, the 12:00:00.000 AM reset time and a small
// binary-to-BCD helper for two-digit fields.
package clock_pkg;

  // disp_time layout: [26] pm, [25:22] hours, [21:16] minutes,
  // [15:10] seconds, [9:0] milliseconds.
  localparam int TIME_W   = 27;
  localparam int PM_BIT   = 26;
  localparam int HOUR_MSB = 25;
  localparam int HOUR_LSB = 22;
  localparam int MIN_MSB  = 21;
  localparam int MIN_LSB  = 16;
  localparam int SEC_MSB  = 15;
  localparam int SEC_LSB  = 10;
  localparam int MS_MSB   = 9;
  localparam int MS_LSB   = 0;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digit codes beyond 0-9 understood by seg7_encode.
  localparam logic [3:0] CODE_DASH  = 4'd14;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  // 12:00:00.000 AM
  localparam logic [TIME_W-1:0] RESET_TIME = {1'b0, 4'd12, 6'd0, 6'd0, 10'd0};

  // Split a 0..63 value into {tens, units}. Only valid BCD for 0..99, which
  // covers every field this is used on.
  function automatic logic [7:0] bin_to_bcd(input logic [5:0] value);
    bin_to_bcd = {4'(value / 6'd10), 4'(value % 6'd10)};
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// seg7_encode -- digit code to active-low seven-segment pattern.
//
// Ports:
//   code  in  4  digit code: 0-9 numerals, 14 = dash, 15 = blank
//   seg   out 7  segments {g,f,e,d,c,b,a}, active-low
// Codes 10-13 are never produced by the display path and render blank.
module seg7_encode
  import clock_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:      seg = SEG_0;
      4'd1:      seg = SEG_1;
      4'd2:      seg = SEG_2;
      4'd3:      seg = SEG_3;
      4'd4:      seg = SEG_4;
      4'd5:      seg = SEG_5;
      4'd6:      seg = SEG_6;
      4'd7:      seg = SEG_7;
      4'd8:      seg = SEG_8;
      4'd9:      seg = SEG_9;
      CODE_DASH: seg = SEG_DASH;
      default:   seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/time_display_mux.sv
// time_display_mux -- four-digit multiplexed seven-segment driver for the
// 12-hour clock.
//
// A 27-bit snapshot of disp_time is taken once per frame (last cycle of the
// last digit slot) so a frame never mixes two different times. Every display
// output is derived from the snapshot and registered.
//
// Parameters:
//   SCAN_DIV    kh_clk cycles per digit slot (1..255)
//   BLANK_LEAD  1 = blank a zero hour-tens digit, 0 = show it
// Ports:
//   kh_clk     in   1  1 kHz clock, only clock of the block
//   reset      in   1  asynchronous, active-high
//   disp_time  in  27  packed time {pm, hours, minutes, seconds, ms}
//   view_sel   in   1  (only with TIME_DISPLAY_SECONDS_VIEW_EN) 1 = MM:SS view
//   seg        out  7  segments {g..a}, active-low
//   an         out  4  digit enables, active-low, an[3] leftmost
//   colon      out  1  colon LED, lit for ms < 500
//   pm_led     out  1  PM indicator
//   time_err   out  1  snapshot holds an out-of-range time
// Build option:
//   TIME_DISPLAY_SECONDS_VIEW_EN  adds view_sel; when set (sampled at frame
//   boundaries) the digits show minute tens/units and second tens/units
//   with no leading-zero blanking.
module time_display_mux
  import clock_pkg::*;
#(
  parameter int SCAN_DIV   = 4,
  parameter int BLANK_LEAD = 1
) (
  input  logic              kh_clk,
  input  logic              reset,
  input  logic [TIME_W-1:0] disp_time,
`ifdef TIME_DISPLAY_SECONDS_VIEW_EN
  input  logic              view_sel,
`endif
  output logic [6:0]        seg,
  output logic [3:0]        an,
  output logic              colon,
  output logic              pm_led,
  output logic              time_err
);

  localparam logic [7:0] SLOT_LAST = 8'(SCAN_DIV - 1);

  logic [7:0]        slot_cnt_reg;
  logic [1:0]        digit_idx_reg;
  logic [TIME_W-1:0] snap_reg;
  logic              slot_wrap;
  logic              frame_end;

  logic [6:0] seg_reg, seg_next;
  logic [3:0] an_reg, an_next;
  logic       colon_reg, pm_led_reg, time_err_reg;

  assign slot_wrap = (slot_cnt_reg == SLOT_LAST);
  assign frame_end = slot_wrap && (digit_idx_reg == 2'd3);

  // Slot/digit scan and the frame-boundary snapshot.
  always_ff @(posedge kh_clk or posedge reset) begin
    if (reset) begin
      slot_cnt_reg  <= '0;
      digit_idx_reg <= '0;
      snap_reg      <= RESET_TIME;
    end else begin
      if (slot_wrap) begin
        slot_cnt_reg  <= '0;
        digit_idx_reg <= digit_idx_reg + 2'd1;
      end else begin
        slot_cnt_reg <= slot_cnt_reg + 8'd1;
      end
      if (frame_end) begin
        snap_reg <= disp_time;
      end
    end
  end

`ifdef TIME_DISPLAY_SECONDS_VIEW_EN
  // The view choice is latched with the snapshot so a frame never switches
  // layout halfway through.
  logic view_reg;

  always_ff @(posedge kh_clk or posedge reset) begin
    if (reset) begin
      view_reg <= 1'b0;
    end else if (frame_end) begin
      view_reg <= view_sel;
    end
  end
`endif

  // Snapshot fields and range check.
  logic       snap_pm;
  logic [3:0] snap_hours;
  logic [5:0] snap_min;
  logic [5:0] snap_sec;
  logic [9:0] snap_ms;
  logic       snap_err;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;

  assign snap_pm    = snap_reg[PM_BIT];
  assign snap_hours = snap_reg[HOUR_MSB:HOUR_LSB];
  assign snap_min   = snap_reg[MIN_MSB:MIN_LSB];
  assign snap_sec   = snap_reg[SEC_MSB:SEC_LSB];
  assign snap_ms    = snap_reg[MS_MSB:MS_LSB];

  assign snap_err = (snap_hours == 4'd0) || (snap_hours > 4'd12) ||
                    (snap_min > 6'd59) || (snap_sec > 6'd59) ||
                    (snap_ms > 10'd999);

  assign hour_bcd = bin_to_bcd({2'b00, snap_hours});
  assign min_bcd  = bin_to_bcd(snap_min);

`ifdef TIME_DISPLAY_SECONDS_VIEW_EN
  logic [7:0] sec_bcd;
  assign sec_bcd = bin_to_bcd(snap_sec);
`endif

  // Digit selection for the slot currently being scanned. An invalid
  // snapshot shows dashes on every digit and suppresses blanking so the
  // fault is obvious.
  logic [3:0] digit_code;
  logic       slot_blank;

  always_comb begin
    digit_code = CODE_BLANK;
    slot_blank = 1'b0;
    if (snap_err) begin
      digit_code = CODE_DASH;
    end
`ifdef TIME_DISPLAY_SECONDS_VIEW_EN
    else if (view_reg) begin
      case (digit_idx_reg)
        2'd0:    digit_code = min_bcd[7:4];
        2'd1:    digit_code = min_bcd[3:0];
        2'd2:    digit_code = sec_bcd[7:4];
        default: digit_code = sec_bcd[3:0];
      endcase
    end
`endif
    else begin
      case (digit_idx_reg)
        2'd0: begin
          if ((BLANK_LEAD != 0) && (hour_bcd[7:4] == 4'd0)) begin
            slot_blank = 1'b1;
            digit_code = CODE_BLANK;
          end else begin
            digit_code = hour_bcd[7:4];
          end
        end
        2'd1:    digit_code = hour_bcd[3:0];
        2'd2:    digit_code = min_bcd[7:4];
        default: digit_code = min_bcd[3:0];
      endcase
    end
  end

  seg7_encode u_seg7_encode (
    .code (digit_code),
    .seg  (seg_next)
  );

  // Index 0 drives an[3] (leftmost), index 3 drives an[0]. A blanked slot
  // leaves every enable high.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_an
      assign an_next[gi] = slot_blank || (digit_idx_reg != 2'(3 - gi));
    end
  endgenerate

  // Registered outputs: they follow the digit index by one cycle, so a new
  // snapshot becomes visible one cycle after the frame boundary.
  always_ff @(posedge kh_clk or posedge reset) begin
    if (reset) begin
      seg_reg      <= SEG_BLANK;
      an_reg       <= 4'b1111;
      colon_reg    <= 1'b0;
      pm_led_reg   <= 1'b0;
      time_err_reg <= 1'b0;
    end else begin
      seg_reg      <= seg_next;
      an_reg       <= an_next;
      colon_reg    <= !snap_err && (snap_ms < 10'd500);
      pm_led_reg   <= snap_pm;
      time_err_reg <= snap_err;
    end
  end

  assign seg      = seg_reg;
  assign an       = an_reg;
  assign colon    = colon_reg;
  assign pm_led   = pm_led_reg;
  assign time_err = time_err_reg;

endmodule

// File: tb/tb_time_display_mux.sv
// tb_time_display_mux -- scoreboard bench for time_display_mux.
//
// Each directed vector is applied mid-frame; its hand-computed display is
// queued for every cycle of the following frame (tagged with the cycle
// number counted from reset release). A separate monitor samples the DUT
// half a clock after each active edge and on reset assertion, popping and
// comparing the entry tagged for that cycle.
module tb_time_display_mux;

  localparam int SCAN_DIV = 4;
  localparam int FRAME    = 4 * SCAN_DIV;

  typedef struct {
    logic [26:0]     t;
    logic            view;
    logic [3:0][6:0] segs;
    logic            blank0;
    logic            colon;
    logic            pm;
    logic            err;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [6:0] seg;
    logic [3:0] an;
    logic       colon;
    logic       pm;
    logic       err;
  } exp_t;

  logic        kh_clk;
  logic        reset;
  logic [26:0] disp_time;
  logic        view_sel;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        colon;
  logic        pm_led;
  logic        time_err;

  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];
  vec_t vecs[$];

  time_display_mux #(
    .SCAN_DIV   (SCAN_DIV),
    .BLANK_LEAD (1)
  ) dut (
    .kh_clk    (kh_clk),
    .reset     (reset),
    .disp_time (disp_time),
`ifdef TIME_DISPLAY_SECONDS_VIEW_EN
    .view_sel  (view_sel),
`endif
    .seg       (seg),
    .an        (an),
    .colon     (colon),
    .pm_led    (pm_led),
    .time_err  (time_err)
  );

  initial kh_clk = 1'b0;
  always #5 kh_clk = ~kh_clk;

  // Posedges since the last reset release.
  always @(posedge kh_clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [26:0] mk(input logic pm, input logic [3:0] h,
                                     input logic [5:0] m, input logic [5:0] s,
                                     input logic [9:0] ms);
    return {pm, h, m, s, ms};
  endfunction

  function automatic vec_t mkv(input logic [26:0] t, input logic view,
                               input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3,
                               input logic blank0, input logic col,
                               input logic pm, input logic err);
    vec_t v;
    v.t = t;
    v.view = view;
    v.segs[0] = s0;
    v.segs[1] = s1;
    v.segs[2] = s2;
    v.segs[3] = s3;
    v.blank0 = blank0;
    v.colon = col;
    v.pm = pm;
    v.err = err;
    return v;
  endfunction

  function automatic logic [3:0] an_slot(input int slot);
    case (slot)
      0:       return 4'b0111;
      1:       return 4'b1011;
      2:       return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  task automatic push_frame(input vec_t v, input int frame, input int count);
    exp_t e;
    for (int k = 1; k <= count; k++) begin
      int slot = (k - 1) / SCAN_DIV;
      e.cyc = FRAME * frame + k;
      if (v.blank0 && slot == 0) begin
        e.an  = 4'b1111;
        e.seg = 7'h7F;
      end else begin
        e.an  = an_slot(slot);
        e.seg = v.segs[slot];
      end
      e.colon = v.colon;
      e.pm    = v.pm;
      e.err   = v.err;
      sb_q.push_back(e);
    end
  endtask

  task automatic push_reset_state();
    exp_t e;
    e.cyc = 0;
    e.seg = 7'h7F;
    e.an = 4'b1111;
    e.colon = 1'b0;
    e.pm = 1'b0;
    e.err = 1'b0;
    sb_q.push_back(e);
  endtask

  // Returns 2 time units after the falling edge that follows posedge n.
  task automatic wait_until(input int n);
    while (cyc != n) @(negedge kh_clk);
    #2;
  endtask

  task automatic apply(input vec_t v, input int idx);
    disp_time = v.t;
    view_sel  = v.view;
    $display("apply vec %0d: disp_time=%h view=%b at cycle %0d", idx, v.t, v.view, cyc);
  endtask

  // Monitor: compare whatever entry is due at this sample point.
  initial begin
    exp_t e;
    forever begin
      @(negedge kh_clk or posedge reset);
      #1;
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        e = sb_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missed_cyc%0d: sampled at cycle %0d, required cycle %0d", e.cyc, cyc, e.cyc);
      end
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        n_checks++;
        if (seg !== e.seg || an !== e.an || colon !== e.colon ||
            pm_led !== e.pm || time_err !== e.err) begin
          n_fail++;
          $display("FAIL disp_cyc%0d: got seg=%h an=%b colon=%b pm=%b err=%b, required seg=%h an=%b colon=%b pm=%b err=%b",
                   e.cyc, seg, an, colon, pm_led, time_err,
                   e.seg, e.an, e.colon, e.pm, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v_rst;
    vec_t v_pm12;
    int   nv;

    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    view_sel  = 1'b0;
    disp_time = mk(1'b1, 4'd3, 6'd21, 6'd4, 10'd600);

    v_rst  = mkv(mk(1'b0, 4'd12, 6'd0, 6'd0, 10'd0), 1'b0,
                 7'h79, 7'h24, 7'h40, 7'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    v_pm12 = mkv(mk(1'b1, 4'd12, 6'd59, 6'd30, 10'd750), 1'b0,
                 7'h79, 7'h24, 7'h12, 7'h10, 1'b0, 1'b0, 1'b1, 1'b0);

    vecs.push_back(mkv(mk(1'b0, 4'd9, 6'd5, 6'd0, 10'd0), 1'b0,
                       7'h7F, 7'h10, 7'h40, 7'h12, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(v_pm12);
    vecs.push_back(mkv(mk(1'b1, 4'd10, 6'd7, 6'd33, 10'd499), 1'b0,
                       7'h79, 7'h40, 7'h40, 7'h78, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mkv(mk(1'b0, 4'd11, 6'd34, 6'd0, 10'd500), 1'b0,
                       7'h79, 7'h79, 7'h30, 7'h19, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkv(mk(1'b0, 4'd3, 6'd60, 6'd0, 10'd0), 1'b0,
                       7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mkv(mk(1'b0, 4'd8, 6'd26, 6'd59, 10'd999), 1'b0,
                       7'h7F, 7'h00, 7'h24, 7'h02, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkv(mk(1'b1, 4'd5, 6'd10, 6'd0, 10'd1000), 1'b0,
                       7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mkv(mk(1'b0, 4'd0, 6'd30, 6'd0, 10'd0), 1'b0,
                       7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mkv(mk(1'b0, 4'd13, 6'd0, 6'd0, 10'd0), 1'b0,
                       7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mkv(mk(1'b1, 4'd6, 6'd48, 6'd0, 10'd250), 1'b0,
                       7'h7F, 7'h02, 7'h19, 7'h00, 1'b1, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mkv(mk(1'b0, 4'd1, 6'd0, 6'd60, 10'd0), 1'b0,
                       7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0, 1'b0, 1'b0, 1'b1));
`ifdef TIME_DISPLAY_SECONDS_VIEW_EN
    vecs.push_back(mkv(mk(1'b1, 4'd10, 6'd7, 6'd33, 10'd499), 1'b1,
                       7'h40, 7'h78, 7'h30, 7'h30, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mkv(mk(1'b0, 4'd9, 6'd5, 6'd0, 10'd0), 1'b1,
                       7'h40, 7'h12, 7'h40, 7'h40, 1'b0, 1'b1, 1'b0, 1'b0));
`endif
    // Last vector: its frame is cut short by a reset at digit index 2.
    vecs.push_back(mkv(mk(1'b0, 4'd7, 6'd15, 6'd0, 10'd0), 1'b0,
                       7'h7F, 7'h78, 7'h79, 7'h12, 1'b1, 1'b1, 1'b0, 1'b0));

    // Reset values while reset is held.
    push_reset_state();
    repeat (3) @(negedge kh_clk);
    #2;
    reset = 1'b0;
    // First frame after release still shows the 12:00:00.000 AM reset time.
    push_frame(v_rst, 0, FRAME);

    nv = vecs.size();
    for (int i = 0; i < nv; i++) begin
      wait_until(FRAME * i + 5);
      apply(vecs[i], i);
      push_frame(vecs[i], i + 1, (i == nv - 1) ? 2 * SCAN_DIV + 1 : FRAME);
    end

    // Now at digit index 2 of the last frame: reset must blank immediately.
    wait_until(FRAME * nv + 2 * SCAN_DIV + 1);
    push_reset_state();
    reset = 1'b1;
    $display("apply reset mid-frame at cycle %0d", FRAME * nv + 2 * SCAN_DIV + 1);
    repeat (2) @(negedge kh_clk);
    #2;
    reset = 1'b0;

    // Scan restarts at index 0 with the reset snapshot, then loads normally.
    push_frame(v_rst, 0, FRAME);
    wait_until(5);
    apply(v_pm12, nv);
    push_frame(v_pm12, 1, FRAME);

    wait_until(2 * FRAME + 1);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_display_mux.md
TIME_DISPLAY_MUX -- requirements
Module: time_display_mux

Interface
REQ-001 Parameter: SCAN_DIV, default 4, meaning kh_clk cycles per digit slot (range 1..255).
REQ-002 Parameter: BLANK_LEAD, default 1, meaning 1 = blank a zero hour-tens digit, 0 = show it.
REQ-003 Port: kh_clk  input  1  1 kHz system clock; the block's only clock.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: disp_time  input  27  packed time from clock_12hr: [26] pm, [25:22] hours binary 1..12, [21:16] minutes 0..59, [15:10] seconds 0..59, [9:0] ms 0..999.
REQ-006 Port: seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-007 Port: an  output  4  digit enables, active-low; an[3] is the leftmost digit.
REQ-008 Port: colon  output  1  colon LED, active-high.
REQ-009 Port: pm_led  output  1  PM indicator, active-high.
REQ-010 Port: time_err  output  1  high while the displayed snapshot is out of range.

Function
REQ-011 SHALL hold a 27-bit snapshot register; all display outputs derive from the snapshot, never directly from disp_time.
REQ-012 Snapshot SHALL load disp_time only on a frame boundary: the cycle where slot counter = SCAN_DIV-1 and digit index = 3. Frames are therefore tear-free.
REQ-013 Slot counter SHALL count 0..SCAN_DIV-1 and wrap to 0; digit index SHALL advance 0->1->2->3->0 on each slot wrap.
REQ-014 Digit map SHALL be: index 0 = hour tens (an[3]), 1 = hour units, 2 = minute tens, 3 = minute units (an[0]).
REQ-015 Binary-to-BCD conversion of hours/minutes SHALL be combinational on the snapshot: tens = value/10, units = value%10.
REQ-016 seg and an SHALL be registered, updating one cycle after the digit index changes; exactly one an bit low per cycle except blanked slots.
REQ-017 With BLANK_LEAD=1 and hour tens = 0, slot 0 SHALL drive an=4'b1111 and seg=7'h7F.
REQ-018 Segment encoding (active-low, {g..a}) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
REQ-019 colon SHALL be high when snapshot ms < 500, otherwise low (1 Hz, 50 % blink).
REQ-020 pm_led SHALL equal snapshot bit [26].
REQ-021 Snapshot hours = 0 or > 12, minutes > 59, seconds > 59, or ms > 999 SHALL set time_err=1; all four digits then show dash (seg=7'h3F), colon low, no blanking.
REQ-022 disp_time changes between frame boundaries SHALL have no effect until the next boundary; visible latency = boundary + 1 cycle.

Reset
REQ-023 Reset SHALL force asynchronously: slot counter 0, digit index 0, snapshot = 12:00:00.000 AM, an=4'b1111, seg=7'h7F, colon=0, pm_led=0, time_err=0.
REQ-024 After reset release, the first snapshot load SHALL occur at the first frame boundary; reset asserted mid-frame SHALL abandon that frame without a snapshot load.

Configuration
REQ-025 Macro TIME_DISPLAY_SECONDS_VIEW_EN: when defined, adds input view_sel (1 bit); view_sel=1 maps digits to minute tens/units, second tens/units, disables leading-zero blanking, and view_sel is sampled only at frame boundaries.
REQ-026 Without TIME_DISPLAY_SECONDS_VIEW_EN, no view_sel port exists and the display is always HH:MM.

Structure
REQ-027 A shared package clock_pkg SHALL hold the disp_time field bit positions, segment code constants (digits 0-9, dash, blank) and the 12:00:00 AM reset value.
REQ-028 One sub-module seg7_encode SHALL map a 4-bit digit code (0-9, 14=dash, 15=blank) to seg; the rest is inline.

Verification
REQ-029 Reset, then disp_time={0,4'd9,6'd5,6'd0,10'd0} -> after one frame: slot0 blanked, slot1 seg=10, slot2 seg=40, slot3 seg=12, pm_led=0.
REQ-030 disp_time hours=12, pm=1, minutes=59 -> slot0 seg=79, slot1 seg=24, slot2 seg=12, slot3 seg=10, pm_led=1.
REQ-031 disp_time changes mid-frame (cycle 5 of 16) -> seg/an stay at the old value until the frame boundary +1 cycle.
REQ-032 ms sweeps 0..999 -> colon high for ms 0..499 and low for ms 500..999.
REQ-033 minutes=60 -> time_err=1, all four slots seg=3F, colon=0; the next valid value clears time_err at the following boundary.
REQ-034 Reset asserted at digit index 2 -> an=1111 and seg=7F in the same cycle; the scan restarts at index 0; with the macro defined, view_sel=1 at 10:07:33 shows 0,7,3,3.
